// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: instruction memory port, redirect request and decode handshake.
// The master modport is the fetch queue; the slave modport is its environment.
interface fetch_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  logic [XLEN-1:0]         IM_Address;
  logic [XLEN-1:0]         IM_Instruction;
  logic                    IM_Ready;
  logic                    Redirect;
  logic [XLEN-1:0]         RedirectPC;
  logic                    ID_Ready;
  logic                    ID_Valid;
  logic [XLEN-1:0]         ID_Instruction;
  logic [XLEN-1:0]         ID_PC4;
  logic [$clog2(DEPTH):0]  Count;

  modport master (
    output IM_Address, ID_Valid, ID_Instruction, ID_PC4, Count,
    input  IM_Instruction, IM_Ready, Redirect, RedirectPC, ID_Ready
  );

  modport slave (
    input  IM_Address, ID_Valid, ID_Instruction, ID_PC4, Count,
    output IM_Instruction, IM_Ready, Redirect, RedirectPC, ID_Ready
  );
endinterface

// File: rtl/fetch_queue.sv
// PC generator plus DEPTH-entry prefetch FIFO; 1-cycle fetch-to-decode latency, no bypass.
// Fetch continues while decode stalls until full; a full queue still accepts a push on a pop.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  fetch_queue_if.master fq
);
  localparam int unsigned     AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CW   = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] ins_q [DEPTH];
  logic [XLEN-1:0] pc4_q [DEPTH];

  logic vld;
  logic pop;
  logic push;

  assign vld  = (cnt_q != '0);
  assign pop  = vld && fq.ID_Ready;
  assign push = fq.IM_Ready && !fq.Redirect && ((cnt_q < FULL) || pop);

  always_comb begin
    pc_d   = pc_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (fq.Redirect) begin
      // A pop in the redirect cycle is consumed by decode but the flush wins.
      pc_d   = fq.RedirectPC;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + STEP;
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q   <= RESET_PC;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge CLK) begin
    if (push && !Reset) begin
      ins_q[wptr_q] <= fq.IM_Instruction;
      pc4_q[wptr_q] <= pc_q + STEP;
    end
  end

  assign fq.IM_Address     = pc_q;
  assign fq.ID_Valid       = vld;
  assign fq.ID_Instruction = vld ? ins_q[rptr_q] : '0;
  assign fq.ID_PC4         = vld ? pc4_q[rptr_q] : '0;
  assign fq.Count          = cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: inputs change and outputs are checked 1 time unit after each rising edge.
module tb_fetch_queue;
  logic CLK = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

  fetch_queue #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .fq   (bus.master)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h8C00_0013;
  endfunction

  assign bus.IM_Instruction = pat(bus.IM_Address);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc4);
    check_eq({tag, " valid"}, 32'(bus.ID_Valid), 32'd1);
    check_eq({tag, " pc4"}, bus.ID_PC4, pc4);
    check_eq({tag, " instr"}, bus.ID_Instruction, pat(pc4 - 32'd4));
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, " valid"}, 32'(bus.ID_Valid), 32'd0);
    check_eq({tag, " pc4"}, bus.ID_PC4, 32'd0);
    check_eq({tag, " instr"}, bus.ID_Instruction, 32'd0);
    check_eq({tag, " count"}, 32'(bus.Count), 32'd0);
  endtask

  initial begin
    Reset          = 1'b1;
    bus.IM_Ready   = 1'b1;
    bus.ID_Ready   = 1'b1;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'h0;
    step();
    step();
    check_empty("reset");
    check_eq("reset addr", bus.IM_Address, 32'h0);

    // Free run: one instruction per cycle, occupancy stays at 1.
    Reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_head($sformatf("run%0d", k), 32'(4 * k));
      check_eq($sformatf("run%0d count", k), 32'(bus.Count), 32'd1);
      check_eq($sformatf("run%0d addr", k), bus.IM_Address, 32'(4 * k));
    end

    // Decode stall from a fresh reset: fill to 4 and hold.
    Reset        = 1'b1;
    bus.ID_Ready = 1'b0;
    step();
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check_eq("fill count", 32'(bus.Count), 32'd4);
    check_eq("fill addr", bus.IM_Address, 32'd16);
    check_head("fill", 32'd4);

    // Release decode: in-order drain while the full queue keeps fetching.
    bus.ID_Ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_head($sformatf("drain%0d", i), 32'(4 + 4 * i));
      check_eq($sformatf("drain%0d count", i), 32'(bus.Count), 32'd4);
      check_eq($sformatf("drain%0d addr", i), bus.IM_Address, 32'(16 + 4 * i));
    end

    // Drop to 3 entries, then redirect.
    bus.IM_Ready = 1'b0;
    step();
    check_eq("pre-redir count", 32'(bus.Count), 32'd3);
    check_eq("pre-redir addr", bus.IM_Address, 32'd32);
    bus.IM_Ready   = 1'b1;
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h100;
    step();
    check_empty("redir");
    check_eq("redir addr", bus.IM_Address, 32'h100);
    bus.Redirect = 1'b0;
    step();
    check_head("post-redir", 32'h104);
    check_eq("post-redir count", 32'(bus.Count), 32'd1);

    // IM_Ready gaps: queue empties on idle fetch cycles.
    for (int i = 0; i < 4; i++) begin
      bus.IM_Ready = i[0];
      step();
      if (i[0]) begin
        check_head($sformatf("gap%0d", i), 32'h104 + 32'(4 * ((i + 1) / 2)));
      end else begin
        check_empty($sformatf("gap%0d", i));
      end
      check_eq($sformatf("gap%0d addr", i), bus.IM_Address, 32'h104 + 32'(4 * ((i + 1) / 2)));
    end

    // PC wrap at the top of the address space.
    bus.IM_Ready   = 1'b1;
    bus.ID_Ready   = 1'b0;
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'hFFFF_FFF8;
    step();
    bus.Redirect = 1'b0;
    step();
    check_head("wrap1", 32'hFFFF_FFFC);
    step();
    check_eq("wrap2 addr", bus.IM_Address, 32'h0);
    check_eq("wrap2 count", 32'(bus.Count), 32'd2);
    step();
    step();
    check_eq("wrap full count", 32'(bus.Count), 32'd4);
    check_eq("wrap full addr", bus.IM_Address, 32'd8);
    bus.ID_Ready = 1'b1;
    step();
    check_head("wrap head", 32'h0);
    check_eq("wrap pop count", 32'(bus.Count), 32'd4);
    check_eq("wrap pop addr", bus.IM_Address, 32'd12);

    // Reset while full, with a coincident redirect that must be ignored.
    Reset          = 1'b1;
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h200;
    step();
    check_empty("rst-full");
    check_eq("rst-full addr", bus.IM_Address, 32'h0);
    Reset        = 1'b0;
    bus.Redirect = 1'b0;
    step();
    check_head("rst-restart", 32'd4);
    check_eq("rst-restart addr", bus.IM_Address, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
